// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decoder types and one-hot helper
//
// Purpose: state and mode enumerations for the sweep decoder family, plus a
//          bounded one-hot helper shared with other decoders.
// Ports:   none (package).
package decoder_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} dec_state_t;
  typedef enum logic {DEC_LEVEL, DEC_PULSE} dec_mode_t;

  // Widest output vector the helper can build; callers truncate to their width.
  localparam int ONEHOT_MAX_W = 64;

  // Returns 1<<idx when idx addresses one of n lines, otherwise all zeros.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                     input int unsigned n);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    if ((idx < n) && (idx < ONEHOT_MAX_W)) v = ONEHOT_MAX_W'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - saturating line index for the all-lines sweep
//
// Purpose: holds the index of the line currently driven by the sweep.
// Ports:   clk, rst_n (async, active-low)
//          clear - reset idx to 0 (sweep entry), wins over inc
//          inc   - advance idx; holds at the last line, never wraps
//          idx   - current line index
//          last  - idx addresses the final line (NUM_OUT-1)
module sweep_counter #(
  parameter int NUM_OUT = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  assign last = (idx == IDX_W'(NUM_OUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/onehot_sweep_decoder.sv
// rtl/onehot_sweep_decoder.sv - registered one-hot decoder with sweep engine
//
// Purpose: registered N-line one-hot decoder (level or pulse mode) with a
//          built-in sweep that asserts every line once, in order, for
//          flush/invalidate-all style operations.
// Ports:   clk, rst_n (async, active-low)
//          enable, sel, pulse_mode - decode request, line index, mode select
//          sweep_start             - start an all-lines sweep (sampled in IDLE)
//          out                     - registered zero-or-one-hot line enables
//          sweep_busy              - high while the sweep drives out
//          sweep_done              - one-cycle pulse after the last sweep line
//          sel_err                 - out-of-range decode request flag
// Build:   define DECODE_ERR_EN to add the sel_err port and its logic.
module onehot_sweep_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [SEL_W-1:0]   sel,
  input  logic               pulse_mode,
  input  logic               sweep_start,
  output logic [NUM_OUT-1:0] out,
  output logic               sweep_busy,
  output logic               sweep_done
`ifdef DECODE_ERR_EN
  ,
  output logic               sel_err
`endif
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  if ((NUM_OUT < 2) || (NUM_OUT > (2 ** SEL_W)) || (NUM_OUT > ONEHOT_MAX_W)) begin : g_param_err
    $error("onehot_sweep_decoder: NUM_OUT must lie in 2..2**SEL_W");
  end

  dec_state_t         state, state_d;
  dec_mode_t          mode;
  logic               enable_q;
  logic               dec_req;
  logic               sel_ok;
  logic [NUM_OUT-1:0] out_d;
  logic               cnt_clear, cnt_inc, cnt_last;
  logic [IDX_W-1:0]   idx;

  assign mode = dec_mode_t'(pulse_mode);

  // Pulse mode only fires on the rising edge of enable; enable_q tracks enable
  // in every state, so an enable held through a sweep cannot fire afterwards.
  assign dec_req = (mode == DEC_PULSE) ? (enable & ~enable_q) : enable;
  assign sel_ok  = (int'(sel) < NUM_OUT);

  sweep_counter #(
    .NUM_OUT (NUM_OUT),
    .IDX_W   (IDX_W)
  ) u_sweep_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .idx   (idx),
    .last  (cnt_last)
  );

`ifdef DECODE_ERR_EN
  logic sel_err_d;
`endif

  always_comb begin
    state_d   = state;
    out_d     = '0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
`ifdef DECODE_ERR_EN
    sel_err_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A sweep request takes priority; any decode in the same cycle is dropped.
        if (sweep_start) begin
          state_d   = SWEEP;
          cnt_clear = 1'b1;
          out_d     = NUM_OUT'(onehot(0, NUM_OUT));
        end else begin
          if (dec_req && sel_ok) out_d = NUM_OUT'(onehot(32'(sel), NUM_OUT));
`ifdef DECODE_ERR_EN
          sel_err_d = dec_req && !sel_ok;
`endif
        end
      end
      SWEEP: begin
        // out already shows line idx; preload the following line or finish.
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
          out_d   = NUM_OUT'(onehot(32'(idx) + 32'd1, NUM_OUT));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out      <= '0;
      enable_q <= 1'b0;
    end else begin
      state    <= state_d;
      out      <= out_d;
      enable_q <= enable;
    end
  end

`ifdef DECODE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= sel_err_d;
  end
`endif

  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);

endmodule
